st_packetizer: RTL and testbench
================================

# st_packetizer

Converts a plain Avalon data stream (data/valid/ready) into an Avalon packet stream (data/start_packet/end_packet/valid/ready). Each word gets packet framing: fixed-length packets of PKT_LEN words, or an early close requested by the producer. The block sits between any st_data source and an st_packet sink. A small registered FIFO decouples the two handshakes and absorbs sink-side backpressure.

## Interface
Parameters:
- DATA_WIDTH, 8, width of the data word.
- PKT_LEN, 16, words per packet (≥1).
- FIFO_DEPTH, 4, buffer entries (power of 2, ≥2).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- sink_data  input  DATA_WIDTH  upstream word.
- sink_valid  input  1  upstream word valid.
- sink_last  input  1  force end_packet on this word; qualified by sink_valid.
- sink_ready  output  1  block can accept a word this cycle.
- source_data  output  DATA_WIDTH  FIFO head word.
- source_start_packet  output  1  head word is first of packet.
- source_end_packet  output  1  head word is last of packet.
- source_valid  output  1  FIFO non-empty.
- source_ready  input  1  downstream accepts head word.
- pkt_count  output  16  completed packets delivered, wraps at 2^16.

## Operation
- Push: sink_valid && sink_ready at a rising edge. Pop: source_valid && source_ready at a rising edge. Ready latency is 0 on both sides.
- Framing is decided at enqueue. Each FIFO entry stores {data, sop, eop}.
- Enqueue beat counter beat_cnt runs 0..PKT_LEN-1 and has width max(1, clog2(PKT_LEN)). Tags for a pushed word:
  - sop = (beat_cnt == 0).
  - eop = (beat_cnt == PKT_LEN-1) || sink_last.
- beat_cnt updates only on a push: it resets to 0 if eop, otherwise increments.
- With PKT_LEN = 1, every word gets both sop and eop.
- sink_last on a word that already has sop yields a one-word packet.
- sink_last is ignored when there is no push.
- FIFO uses read/write pointers (log2 FIFO_DEPTH bits, natural wrap) and an occupancy count (0..FIFO_DEPTH).
- sink_ready = reset && (count < FIFO_DEPTH). It depends only on registered state; there is no combinational path from source_ready.
- source_valid = (count != 0).
- source_start_packet and source_end_packet are the head entry's tags ANDed with source_valid, so both are 0 when empty.
- Push and pop in the same cycle leave count unchanged. This is legal at any count below FIFO_DEPTH. When full, push is impossible.
- pkt_count increments on every pop whose entry has eop set.
- No state machine beyond beat_cnt and the FIFO; packets are never dropped or reordered.

## Timing
- Reset (reset = 0 at an edge) clears, by the next cycle:
  - count, both pointers, beat_cnt and pkt_count to 0;
  - FIFO storage to 0.
- Resulting outputs: source_valid = 0, source_start_packet = 0, source_end_packet = 0, source_data = 0.
- While reset is low, sink_ready = 0 and no push occurs.
- Reset mid-packet discards all buffered words and the partial-packet position. The first word after reset carries sop.
- Latency: a word pushed at edge k drives source_* during the cycle after edge k. It can pop at edge k+1.
- Throughput: one word per cycle sustained with source_ready held high.
- Full: sink_ready falls in the cycle after the push that reaches FIFO_DEPTH. It rises in the cycle after the first pop.
- Output stability: source_data and flags stay stable while source_valid && !source_ready.

## Test plan
- Reset: hold reset low 3 cycles with sink_valid = 1 -> sink_ready = 0, source_valid = 0, pkt_count = 0. Nothing appears after release until a new push.
- Framing (PKT_LEN = 4, source_ready = 1): push 0x10..0x17 back-to-back ->
  - output is the same order, one-cycle latency;
  - sop on 0x10 and 0x14, eop on 0x13 and 0x17;
  - pkt_count = 2; no bubbles.
- Backpressure (FIFO_DEPTH = 4): source_ready = 0, offer 0x30..0x34 ->
  - sink_ready = 0 after 0x33 is accepted; 0x34 is held;
  - raise source_ready -> all five words emerge in order and sink_ready reasserts one cycle after the first pop.
- Early close (PKT_LEN = 4): push 0x20, 0x21, then 0x22 with sink_last = 1, then 0x23 ->
  - eop on 0x22, sop on 0x23, pkt_count = 1 after 0x22 pops;
  - sink_last asserted with sink_valid = 0 has no effect.
- Reset mid-packet (PKT_LEN = 4): push 0x40, 0x41, pulse reset, push 0x42 -> only 0x42 is output, with sop = 1 and pkt_count = 0.
- PKT_LEN = 1 plus random ready/valid (10k cycles) -> every word has sop = eop = 1. Scoreboard shows pkt_count equals the number of words delivered and no loss or reorder.

Source files
------------

// File: rtl/st_packetizer_if.sv
// Handshake bundle for st_packetizer: plain st_data in, framed st_packet out.
// master = the environment (producer and consumer), slave = the packetizer.
interface st_packetizer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] sink_data;
  logic                  sink_valid;
  logic                  sink_last;
  logic                  sink_ready;
  logic [DATA_WIDTH-1:0] source_data;
  logic                  source_start_packet;
  logic                  source_end_packet;
  logic                  source_valid;
  logic                  source_ready;

  modport master (
    output sink_data, sink_valid, sink_last, source_ready,
    input  sink_ready, source_data, source_start_packet, source_end_packet, source_valid
  );

  modport slave (
    input  sink_data, sink_valid, sink_last, source_ready,
    output sink_ready, source_data, source_start_packet, source_end_packet, source_valid
  );
endinterface

// File: rtl/st_packetizer.sv
// Tags each incoming word with sop/eop at enqueue (fixed length or early close)
// and buffers {data, sop, eop} in a small registered FIFO toward the packet sink.
module st_packetizer #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  st_packetizer_if.slave    st,
  output logic [15:0]       pkt_count
);
  localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = DATA_WIDTH + 2;
  localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [EW-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic [15:0]   pkt_count_q, pkt_count_d;

  logic          push, pop, tag_sop, tag_eop, not_empty;
  logic [EW-1:0] head;

  assign not_empty = (count_q != '0);
  assign head      = mem_q[rd_ptr_q];

  // Ready looks only at registered occupancy, never at source_ready.
  assign st.sink_ready          = reset && (count_q < FULL_CNT);
  assign st.source_valid        = not_empty;
  assign st.source_data         = head[EW-1:2];
  assign st.source_start_packet = head[1] & not_empty;
  assign st.source_end_packet   = head[0] & not_empty;
  assign pkt_count              = pkt_count_q;

  assign push    = st.sink_valid && st.sink_ready;
  assign pop     = not_empty && st.source_ready;
  assign tag_sop = (beat_cnt_q == '0);
  assign tag_eop = (beat_cnt_q == LAST_BEAT) || st.sink_last;

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    beat_cnt_d  = beat_cnt_q;
    pkt_count_d = pkt_count_q;

    if (push) begin
      mem_d[wr_ptr_q] = {st.sink_data, tag_sop, tag_eop};
      wr_ptr_d        = wr_ptr_q + 1'b1;
      beat_cnt_d      = tag_eop ? '0 : beat_cnt_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      if (head[0]) pkt_count_d = pkt_count_q + 16'd1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      beat_cnt_q  <= '0;
      pkt_count_q <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      beat_cnt_q  <= beat_cnt_d;
      pkt_count_q <= pkt_count_d;
    end
  end
endmodule

// File: tb/tb_st_packetizer.sv
// Bench for st_packetizer: queue-based model per DUT checked every cycle, plus
// directed framing/backpressure/early-close/reset tests and a PKT_LEN=1 random run.
module tb_st_packetizer;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } ent_t;

  typedef struct {
    ent_t e;
    int   cyc;
  } pop_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] pc4_dut, pc1_dut;
  int          n_cmp, n_err, cyc;

  st_packetizer_if #(.DATA_WIDTH(8)) if4 ();
  st_packetizer_if #(.DATA_WIDTH(8)) if1 ();

  st_packetizer #(.DATA_WIDTH(8), .PKT_LEN(4), .FIFO_DEPTH(DEPTH)) dut4 (
    .clk(clk), .reset(rst_n), .st(if4), .pkt_count(pc4_dut)
  );
  st_packetizer #(.DATA_WIDTH(8), .PKT_LEN(1), .FIFO_DEPTH(DEPTH)) dut1 (
    .clk(clk), .reset(rst_n), .st(if1), .pkt_count(pc1_dut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Packet position of the next accepted word, as a plain integer within the packet.
  function automatic ent_t frame(input int len, inout int pos, input logic [7:0] d, input logic last);
    ent_t e;
    e.data = d;
    e.sop  = (pos == 0);
    e.eop  = (pos == len - 1) || last;
    pos    = e.eop ? 0 : pos + 1;
    return e;
  endfunction

  ent_t        q4[$], q1[$];
  pop_t        log4[$];
  int          pos4, pos1, del1;
  logic [15:0] pc4, pc1;

  always @(negedge clk) begin
    bit pu, po;
    chk("m4_sink_ready", 32'(if4.sink_ready), 32'(rst_n && q4.size() < DEPTH));
    chk("m4_valid", 32'(if4.source_valid), 32'(q4.size() != 0));
    if (q4.size() != 0) begin
      chk("m4_data", 32'(if4.source_data), 32'(q4[0].data));
      chk("m4_sop", 32'(if4.source_start_packet), 32'(q4[0].sop));
      chk("m4_eop", 32'(if4.source_end_packet), 32'(q4[0].eop));
    end else begin
      chk("m4_sop_empty", 32'(if4.source_start_packet), 32'd0);
      chk("m4_eop_empty", 32'(if4.source_end_packet), 32'd0);
    end
    chk("m4_pkt_count", 32'(pc4_dut), 32'(pc4));
    if (!rst_n) begin
      q4.delete(); pos4 = 0; pc4 = '0;
    end else begin
      po = (q4.size() != 0) && if4.source_ready;
      pu = if4.sink_valid && (q4.size() < DEPTH);
      if (po) begin
        log4.push_back('{e: q4[0], cyc: cyc});
        if (q4[0].eop) pc4 = pc4 + 16'd1;
        void'(q4.pop_front());
      end
      if (pu) q4.push_back(frame(4, pos4, if4.sink_data, if4.sink_last));
    end
  end

  always @(negedge clk) begin
    bit pu, po;
    chk("m1_sink_ready", 32'(if1.sink_ready), 32'(rst_n && q1.size() < DEPTH));
    chk("m1_valid", 32'(if1.source_valid), 32'(q1.size() != 0));
    if (q1.size() != 0) begin
      chk("m1_data", 32'(if1.source_data), 32'(q1[0].data));
      chk("m1_sop", 32'(if1.source_start_packet), 32'(q1[0].sop));
      chk("m1_eop", 32'(if1.source_end_packet), 32'(q1[0].eop));
    end
    chk("m1_pkt_count", 32'(pc1_dut), 32'(pc1));
    if (!rst_n) begin
      q1.delete(); pos1 = 0; pc1 = '0;
    end else begin
      po = (q1.size() != 0) && if1.source_ready;
      pu = if1.sink_valid && (q1.size() < DEPTH);
      if (po) begin
        del1++;
        if (q1[0].eop) pc1 = pc1 + 16'd1;
        void'(q1.pop_front());
      end
      if (pu) q1.push_back(frame(1, pos1, if1.sink_data, if1.sink_last));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic v, input logic [7:0] d, input logic l);
    if4.sink_valid = v;
    if4.sink_data  = d;
    if4.sink_last  = l;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0;
    pos4 = 0; pos1 = 0; pc4 = '0; pc1 = '0; del1 = 0;
    rst_n = 1'b0;
    drive4(1'b1, 8'h55, 1'b0);
    if4.source_ready = 1'b0;
    if1.sink_valid = 1'b0; if1.sink_data = '0; if1.sink_last = 1'b0; if1.source_ready = 1'b0;

    // Reset held with sink_valid high
    repeat (3) begin
      tick();
      chk("rst_sink_ready", 32'(if4.sink_ready), 32'd0);
      chk("rst_source_valid", 32'(if4.source_valid), 32'd0);
      chk("rst_pkt_count", 32'(pc4_dut), 32'd0);
    end
    chk("rst_source_data", 32'(if4.source_data), 32'd0);
    rst_n = 1'b1;
    drive4(1'b0, 8'h00, 1'b0);
    repeat (3) tick();
    chk("post_rst_idle_valid", 32'(if4.source_valid), 32'd0);
    chk("post_rst_sink_ready", 32'(if4.sink_ready), 32'd1);

    // Framing: 8 words back-to-back, drained at full rate
    if4.source_ready = 1'b1;
    log4.delete();
    for (int i = 0; i < 8; i++) begin
      drive4(1'b1, 8'(8'h10 + i), 1'b0);
      tick();
    end
    drive4(1'b0, 8'h00, 1'b0);
    repeat (4) tick();
    chk("frm_count", 32'(log4.size()), 32'd8);
    for (int i = 0; i < 8 && i < log4.size(); i++) begin
      chk("frm_data", 32'(log4[i].e.data), 32'(8'h10 + i));
      chk("frm_sop", 32'(log4[i].e.sop), 32'(i == 0 || i == 4));
      chk("frm_eop", 32'(log4[i].e.eop), 32'(i == 3 || i == 7));
      if (i > 0) chk("frm_no_bubble", 32'(log4[i].cyc - log4[i-1].cyc), 32'd1);
    end
    chk("frm_pkt_count", 32'(pc4_dut), 32'd2);

    // Backpressure: fill to 4, hold the fifth word
    if4.source_ready = 1'b0;
    log4.delete();
    for (int i = 0; i < 4; i++) begin
      drive4(1'b1, 8'(8'h30 + i), 1'b0);
      tick();
    end
    drive4(1'b1, 8'h34, 1'b0);
    tick(); tick();
    chk("bp_full_ready", 32'(if4.sink_ready), 32'd0);
    chk("bp_head_stable", 32'(if4.source_data), 32'h30);
    if4.source_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_before_pop", 32'(if4.sink_ready), 32'd0);
    tick();
    chk("bp_ready_after_pop", 32'(if4.sink_ready), 32'd1);
    tick();
    drive4(1'b0, 8'h00, 1'b0);
    repeat (6) tick();
    chk("bp_count", 32'(log4.size()), 32'd5);
    for (int i = 0; i < 5 && i < log4.size(); i++)
      chk("bp_order", 32'(log4[i].e.data), 32'(8'h30 + i));
    chk("bp_pkt_count", 32'(pc4_dut), 32'd3);

    // Early close, with a stray sink_last while idle
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("ec_pkt_count_rst", 32'(pc4_dut), 32'd0);
    log4.delete();
    drive4(1'b1, 8'h20, 1'b0); tick();
    drive4(1'b0, 8'h00, 1'b1); tick();
    drive4(1'b1, 8'h21, 1'b0); tick();
    drive4(1'b1, 8'h22, 1'b1); tick();
    drive4(1'b1, 8'h23, 1'b0); tick();
    drive4(1'b0, 8'h00, 1'b0);
    repeat (4) tick();
    chk("ec_count", 32'(log4.size()), 32'd4);
    if (log4.size() == 4) begin
      chk("ec_20_sop", 32'({log4[0].e.sop, log4[0].e.eop}), 32'b10);
      chk("ec_21_flags", 32'({log4[1].e.sop, log4[1].e.eop}), 32'b00);
      chk("ec_22_eop", 32'({log4[2].e.data, log4[2].e.eop}), 32'h045);
      chk("ec_23_sop", 32'({log4[3].e.data, log4[3].e.sop, log4[3].e.eop}), 32'h08e);
    end
    chk("ec_pkt_count", 32'(pc4_dut), 32'd1);

    // Reset mid-packet
    if4.source_ready = 1'b0;
    log4.delete();
    drive4(1'b1, 8'h40, 1'b0); tick();
    drive4(1'b1, 8'h41, 1'b0); tick();
    drive4(1'b0, 8'h00, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_empty", 32'(if4.source_valid), 32'd0);
    if4.source_ready = 1'b1;
    drive4(1'b1, 8'h42, 1'b0); tick();
    drive4(1'b0, 8'h00, 1'b0);
    repeat (3) tick();
    chk("mid_rst_count", 32'(log4.size()), 32'd1);
    if (log4.size() == 1)
      chk("mid_rst_42", 32'({log4[0].e.data, log4[0].e.sop, log4[0].e.eop}), 32'h10a);
    chk("mid_rst_pkt_count", 32'(pc4_dut), 32'd0);

    // PKT_LEN=1 random valid/ready
    del1 = 0;
    for (int i = 0; i < 10000; i++) begin
      if1.sink_valid   = 1'($urandom_range(0, 1));
      if1.sink_data    = 8'($urandom_range(0, 255));
      if1.sink_last    = 1'($urandom_range(0, 1));
      if1.source_ready = 1'($urandom_range(0, 1));
      tick();
    end
    if1.sink_valid = 1'b0; if1.sink_last = 1'b0; if1.source_ready = 1'b1;
    repeat (8) tick();
    chk("rnd_drained", 32'(if1.source_valid), 32'd0);
    chk("rnd_some_traffic", 32'(del1 > 1000), 32'd1);
    chk("rnd_pkt_eq_words", 32'(pc1_dut), 32'(16'(del1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end
endmodule
